// File: rtl/seven_seg_scan_decoder.sv
// Loopback checker for a multiplexed active-low seven-segment bus: reconstructs
// the hex value shown on each digit and flags blank, unknown and ghosting samples.
module seven_seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg_val,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx,
    output logic                    err_pattern,
    output logic                    err_ghost
);

    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [6:0]  BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [NUM_DIGITS-1:0] s_an, p_an;
    logic [6:0]            s_seg, p_seg;

    logic [NUM_DIGITS-1:0] lows_c;
    logic                  is_sel_c, is_ghost_c, same_c, start_c, cont_c, capture_c;
    logic [IW-1:0]         sel_idx_c;
    logic [CW-1:0]         nxt_cnt_c;
    logic [4:0]            dec_c;
    logic                  unused_c;

    assign unused_c = seg_val[7];

    // Team segment encoding; returns {recognised, value}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40: decode = 5'h10;
            7'h79: decode = 5'h11;
            7'h24: decode = 5'h12;
            7'h30: decode = 5'h13;
            7'h19: decode = 5'h14;
            7'h12: decode = 5'h15;
            7'h02: decode = 5'h16;
            7'h78: decode = 5'h17;
            7'h00: decode = 5'h18;
            7'h18: decode = 5'h19;
            7'h08: decode = 5'h1A;
            7'h03: decode = 5'h1B;
            7'h46: decode = 5'h1C;
            7'h21: decode = 5'h1D;
            7'h06: decode = 5'h1E;
            7'h0E: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    // Classify the registered sample and work out the dwell counter update.
    always_comb begin
        lows_c     = ~s_an;
        is_sel_c   = (lows_c != '0) && ((lows_c & (lows_c - NUM_DIGITS'(1))) == '0);
        is_ghost_c = (lows_c != '0) && !is_sel_c;
        sel_idx_c  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (lows_c[i]) sel_idx_c = IW'(i);
        end
        same_c    = (s_an == p_an) && (s_seg == p_seg);
        start_c   = is_sel_c && ((state == IDLE) || !same_c);
        cont_c    = is_sel_c && (state == TRACK) && same_c;
        nxt_cnt_c = start_c ? CW'(1) : (cnt + CW'(1));
        capture_c = (start_c || cont_c) && (nxt_cnt_c == CW'(STABLE_CYCLES));
        dec_c     = decode(s_seg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            s_an        <= '1;
            p_an        <= '1;
            s_seg       <= '1;
            p_seg       <= '1;
            digits      <= '0;
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
            err_pattern <= 1'b0;
            err_ghost   <= 1'b0;
        end else begin
            s_an        <= an;
            s_seg       <= seg_val[6:0];
            p_an        <= s_an;
            p_seg       <= s_seg;
            upd         <= 1'b0;
            err_ghost   <= is_ghost_c | (err_ghost & ~err_clr);
            err_pattern <= err_pattern & ~err_clr;

            if (!is_sel_c) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (capture_c) begin
                state   <= HELD;
                cnt     <= nxt_cnt_c;
                upd     <= 1'b1;
                upd_idx <= sel_idx_c;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (IW'(i) == sel_idx_c) begin
                        if (dec_c[4]) digits[4*i +: 4] <= dec_c[3:0];
                        digit_valid[i] <= dec_c[4];
                    end
                end
                // New error outranks a simultaneous clear.
                if (!dec_c[4] && (s_seg != BLANK)) err_pattern <= 1'b1;
            end else if (start_c || cont_c) begin
                state <= TRACK;
                cnt   <= nxt_cnt_c;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: table of dwells plus hand-written
// sequences for flicker, ghosting, error clearing and mid-dwell reset.
module tb_seven_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_val;
    logic [3:0]  an;
    logic        err_clr;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        err_pattern;
    logic        err_ghost;

    seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .seg_val(seg_val), .an(an), .err_clr(err_clr),
        .digits(digits), .digit_valid(digit_valid), .upd(upd), .upd_idx(upd_idx),
        .err_pattern(err_pattern), .err_ghost(err_ghost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        int         hold;
        int         idx;
        logic [3:0] val;
        logic       vld;
        logic       err;
    } row_t;

    row_t rows[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   ups;
    int   last_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (upd === 1'b1) begin
            ups++;
            last_idx = int'(upd_idx);
        end
    endtask

    task automatic idle_bus();
        an      = 4'hF;
        seg_val = 8'hFF;
    endtask

    initial begin
        rows.push_back('{4'b1110, 8'h24, 20, 0, 4'h2, 1'b1, 1'b0});
        rows.push_back('{4'b0111, 8'h0E,  8, 3, 4'hF, 1'b1, 1'b0});
        rows.push_back('{4'b1011, 8'h06,  8, 2, 4'hE, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h21,  8, 1, 4'hD, 1'b1, 1'b0});
        rows.push_back('{4'b1110, 8'h46,  8, 0, 4'hC, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'hC0,  4, 1, 4'h0, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h79,  4, 1, 4'h1, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h24,  4, 1, 4'h2, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h30,  4, 1, 4'h3, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h19,  4, 1, 4'h4, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h92,  4, 1, 4'h5, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h02,  4, 1, 4'h6, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h78,  4, 1, 4'h7, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h00,  4, 1, 4'h8, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h18,  4, 1, 4'h9, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h08,  4, 1, 4'hA, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h03,  4, 1, 4'hB, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h46,  4, 1, 4'hC, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h21,  4, 1, 4'hD, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h06,  4, 1, 4'hE, 1'b1, 1'b0});
        rows.push_back('{4'b1101, 8'h0E,  4, 1, 4'hF, 1'b1, 1'b0});
        rows.push_back('{4'b1011, 8'h00,  4, 2, 4'h8, 1'b1, 1'b0});
        rows.push_back('{4'b1011, 8'h7F,  4, 2, 4'h8, 1'b0, 1'b0});
        rows.push_back('{4'b1011, 8'h55,  4, 2, 4'h8, 1'b0, 1'b1});

        rst = 1'b1;
        err_clr = 1'b0;
        idle_bus();
        #1;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_upd", 32'(upd), 32'h0);
        check("reset_errs", 32'({err_pattern, err_ghost}), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        foreach (rows[k]) begin
            an = rows[k].an;
            seg_val = rows[k].seg;
            ups = 0;
            last_idx = -1;
            repeat (rows[k].hold) tick();
            idle_bus();
            tick();
            check($sformatf("row%0d_upd_count", k), 32'(ups), 32'd1);
            check($sformatf("row%0d_upd_idx", k), 32'(last_idx), 32'(rows[k].idx));
            check($sformatf("row%0d_digit", k), 32'(digits[rows[k].idx*4 +: 4]), 32'(rows[k].val));
            check($sformatf("row%0d_valid", k), 32'(digit_valid[rows[k].idx]), 32'(rows[k].vld));
            check($sformatf("row%0d_err_pattern", k), 32'(err_pattern), 32'(rows[k].err));
        end
        check("table_digits", 32'(digits), 32'hF8FC);
        check("table_valid", 32'(digit_valid), 32'hB);

        // Sticky pattern error clears on err_clr.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_pattern_clr", 32'(err_pattern), 32'h0);

        // Flicker on digit 1 never settles long enough to capture.
        ups = 0;
        an = 4'b1101;
        for (int c = 0; c < 6; c++) begin
            seg_val = (c % 2 == 0) ? 8'h79 : 8'h24;
            repeat (3) tick();
        end
        check("flicker_no_upd", 32'(ups), 32'h0);
        check("flicker_digit_kept", 32'(digits[7:4]), 32'hF);
        seg_val = 8'h79;
        repeat (4) tick();
        idle_bus();
        tick();
        check("settled_upd_count", 32'(ups), 32'd1);
        check("settled_digit", 32'(digits[7:4]), 32'h1);

        // Single-cycle ghost sample.
        ups = 0;
        an = 4'b1100;
        seg_val = 8'h24;
        tick();
        idle_bus();
        check("ghost_not_yet", 32'(err_ghost), 32'h0);
        tick();
        check("ghost_set", 32'(err_ghost), 32'h1);
        repeat (4) tick();
        check("ghost_no_upd", 32'(ups), 32'h0);
        an = 4'b0011;
        tick();
        idle_bus();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ghost_beats_clr", 32'(err_ghost), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ghost_clr", 32'(err_ghost), 32'h0);

        // Reset part-way through a dwell (counter at 3).
        ups = 0;
        an = 4'b1110;
        seg_val = 8'h79;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("midrst_digits", 32'(digits), 32'h0);
        check("midrst_valid", 32'(digit_valid), 32'h0);
        check("midrst_upd", 32'({upd, upd_idx}), 32'h0);
        check("midrst_errs", 32'({err_pattern, err_ghost}), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        ups = 0;
        repeat (4) tick();
        check("midrst_no_partial", 32'(ups), 32'h0);
        tick();
        check("midrst_fresh_upd", 32'(upd), 32'h1);
        check("midrst_fresh_idx", 32'(upd_idx), 32'h0);
        check("midrst_fresh_digit", 32'(digits[3:0]), 32'h1);
        idle_bus();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
